// File: rtl/encoder_8_to_3_seq_if.sv
// Handshake bundle for encoder_8_to_3_seq: request-vector channel in, binary-code channel out.
// The slave modport is the encoder's view; master is the view of whatever drives it.
interface encoder_8_to_3_seq_if #(
  parameter int W = 3
);
  localparam int N = 2 ** W;

  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_bits;
  logic         code_valid;
  logic         code_ready;
  logic [W-1:0] code;
  logic         code_last;

  modport master (
    output req_valid,
    output req_bits,
    output code_ready,
    input  req_ready,
    input  code_valid,
    input  code,
    input  code_last
  );

  modport slave (
    input  req_valid,
    input  req_bits,
    input  code_ready,
    output req_ready,
    output code_valid,
    output code,
    output code_last
  );
endinterface

// File: rtl/encoder_8_to_3_seq.sv
// Sequential 2**W-to-W encoder: emits the index of every set request bit, lowest first, one per handshake.
// Optional ENC_DONE_PULSE_EN adds a one-cycle 'done' pulse after each vector has been fully consumed.
module encoder_8_to_3_seq #(
  parameter int W = 3
) (
  input  logic                      clk,
  input  logic                      nrst,
`ifdef ENC_DONE_PULSE_EN
  output logic                      done,
`endif
  encoder_8_to_3_seq_if.slave       bus
);
  localparam int N = 2 ** W;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic         ready_en_q, ready_en_d;

  logic [N-1:0] first_hot;
  logic [N-1:0] remaining;
  logic [W-1:0] low_idx;
  logic         single;
  logic         accept;
  logic         transfer;

  // Bit gi set for every vector position whose index has bit gi set.
  function automatic logic [N-1:0] index_mask(input int b);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = ((i >> b) & 1) == 1;
    end
    return m;
  endfunction

  // Two's-complement trick isolates the lowest set bit of pending.
  assign first_hot = pending_q & (~pending_q + N'(1));
  assign remaining = pending_q & ~first_hot;
  assign single    = (pending_q != '0) && (remaining == '0);

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_code_bit
      assign low_idx[gi] = |(first_hot & index_mask(gi));
    end
  endgenerate

  // Every output is a decode of registered state only.
  assign bus.req_ready  = (state_q == IDLE) && ready_en_q;
  assign bus.code_valid = (state_q == SEND);
  assign bus.code       = low_idx;
  assign bus.code_last  = (state_q == SEND) && single;

  assign accept   = bus.req_valid && bus.req_ready;
  assign transfer = bus.code_valid && bus.code_ready;

`ifdef ENC_DONE_PULSE_EN
  logic done_q, done_d;
  assign done = done_q;
`else
  // No completion pulse is formed in this build.
`endif

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    ready_en_d = 1'b1;
`ifdef ENC_DONE_PULSE_EN
    done_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (bus.req_bits != '0) begin
            pending_d = bus.req_bits;
            state_d   = SEND;
          end else begin
`ifdef ENC_DONE_PULSE_EN
            done_d = 1'b1;
`endif
          end
        end
      end
      SEND: begin
        if (transfer) begin
          pending_d = remaining;
          if (single) begin
            state_d = IDLE;
`ifdef ENC_DONE_PULSE_EN
            done_d  = 1'b1;
`endif
          end
        end
      end
      default: begin
        state_d   = IDLE;
        pending_d = '0;
      end
    endcase
  end

  // ready_en_q keeps req_ready low until one clean edge has passed after reset.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q    <= IDLE;
      pending_q  <= '0;
      ready_en_q <= 1'b0;
`ifdef ENC_DONE_PULSE_EN
      done_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      ready_en_q <= ready_en_d;
`ifdef ENC_DONE_PULSE_EN
      done_q     <= done_d;
`endif
    end
  end
endmodule

// File: tb/tb_encoder_8_to_3_seq.sv
// Directed bench for encoder_8_to_3_seq: reset, ordering, backpressure, zero/single, round-trip, mid-send reset.
module tb_encoder_8_to_3_seq;
  localparam int W = 3;
  localparam int N = 8;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  encoder_8_to_3_seq_if #(.W(W)) bus ();
`ifdef ENC_DONE_PULSE_EN
  logic done;
`endif

  encoder_8_to_3_seq #(.W(W)) dut (
    .clk  (clk),
    .nrst (nrst),
`ifdef ENC_DONE_PULSE_EN
    .done (done),
`endif
    .bus  (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [N-1:0] vec);
    bus.req_valid = 1'b1;
    bus.req_bits  = vec;
    tick();
    bus.req_valid = 1'b0;
    bus.req_bits  = '0;
  endtask

  function automatic logic [N-1:0] dec3to8(input logic [W-1:0] c);
    logic [N-1:0] one;
    one = 1;
    return one << c;
  endfunction

  task automatic test_reset();
    nrst = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_bits   = '0;
    bus.code_ready = 1'b0;
    repeat (2) tick();
    tests_run++;
    if (bus.req_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ready_low got=%b exp=0", bus.req_ready);
    end
    tests_run++;
    if (bus.code_valid !== 1'b0 || bus.code !== 3'd0 || bus.code_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_outputs got valid=%b code=%0d last=%b exp 0/0/0",
               bus.code_valid, bus.code, bus.code_last);
    end
    nrst = 1'b1;
    tick();
    tests_run++;
    if (bus.req_ready !== 1'b1 || bus.code_valid !== 1'b0 || bus.code !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_release got ready=%b valid=%b code=%0d exp 1/0/0",
               bus.req_ready, bus.code_valid, bus.code);
    end
`ifdef ENC_DONE_PULSE_EN
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_done got=%b exp=0", done);
    end
`endif
    $display("[TB] reset: released, ready=%b", bus.req_ready);
  endtask

  task automatic test_mixed();
    int exp_codes [4];
    exp_codes = '{1, 2, 5, 7};
    bus.code_ready = 1'b1;
    offer(8'b1010_0110);
    for (int j = 0; j < 4; j++) begin
      tests_run++;
      if (bus.code_valid !== 1'b1 || bus.code !== 3'(exp_codes[j]) ||
          bus.code_last !== (j == 3) || bus.req_ready !== 1'b0) begin
        tests_failed++;
        $display("FAIL mixed_code%0d got valid=%b code=%0d last=%b ready=%b exp 1/%0d/%0b/0",
                 j, bus.code_valid, bus.code, bus.code_last, bus.req_ready, exp_codes[j], (j == 3));
      end
      tick();
    end
    tests_run++;
    if (bus.code_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL mixed_idle got valid=%b ready=%b exp 0/1", bus.code_valid, bus.req_ready);
    end
`ifdef ENC_DONE_PULSE_EN
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL mixed_done_pulse got=%b exp=1", done);
    end
    tick();
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL mixed_done_single got=%b exp=0", done);
    end
`endif
    $display("[TB] mixed: vector a6 -> codes 1 2 5 7");
  endtask

  task automatic test_backpressure();
    bus.code_ready = 1'b0;
    offer(8'b0001_1000);
    // A stray request during SEND must be ignored.
    bus.req_valid = 1'b1;
    bus.req_bits  = 8'h01;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        bus.code_ready = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_bits   = '0;
      end
      tests_run++;
      if (bus.code_valid !== 1'b1 || bus.code !== 3'd3 || bus.code_last !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold%0d got valid=%b code=%0d last=%b exp 1/3/0",
                 i, bus.code_valid, bus.code, bus.code_last);
      end
      tick();
    end
    tests_run++;
    if (bus.code_valid !== 1'b1 || bus.code !== 3'd4 || bus.code_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_second got valid=%b code=%0d last=%b exp 1/4/1",
               bus.code_valid, bus.code, bus.code_last);
    end
    tick();
    tests_run++;
    if (bus.code_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL bp_idle got valid=%b ready=%b exp 0/1", bus.code_valid, bus.req_ready);
    end
    $display("[TB] backpressure: vector 18 -> code 3 held 4 cycles, then 4");
  endtask

  task automatic test_zero_single();
    bus.code_ready = 1'b1;
    offer(8'h00);
    tests_run++;
    if (bus.code_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_vec got valid=%b ready=%b exp 0/1", bus.code_valid, bus.req_ready);
    end
`ifdef ENC_DONE_PULSE_EN
    tests_run++;
    if (done !== 1'b1) begin
      tests_failed++;
      $display("FAIL zero_done got=%b exp=1", done);
    end
`endif
    tick();
    tests_run++;
    if (bus.code_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_no_code got valid=%b exp=0", bus.code_valid);
    end
`ifdef ENC_DONE_PULSE_EN
    tests_run++;
    if (done !== 1'b0) begin
      tests_failed++;
      $display("FAIL zero_done_once got=%b exp=0", done);
    end
`endif
    offer(8'h80);
    tests_run++;
    if (bus.code_valid !== 1'b1 || bus.code !== 3'd7 || bus.code_last !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_top got valid=%b code=%0d last=%b exp 1/7/1",
               bus.code_valid, bus.code, bus.code_last);
    end
    tick();
    tests_run++;
    if (bus.code_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_idle got valid=%b ready=%b exp 0/1", bus.code_valid, bus.req_ready);
    end
    $display("[TB] zero/single: vector 00 dropped, vector 80 -> code 7");
  endtask

  task automatic test_roundtrip();
    bus.code_ready = 1'b1;
    for (int v = 0; v < 256; v++) begin
      logic [N-1:0] vec;
      logic [N-1:0] acc;
      logic         exp_last;
      int           prev;
      int           cyc;
      int           idx;
      vec  = 8'(v);
      acc  = '0;
      prev = -1;
      cyc  = 0;
      offer(vec);
      while (bus.code_valid === 1'b1 && cyc <= N) begin
        idx = int'(bus.code);
        tests_run++;
        if (idx <= prev || vec[idx] !== 1'b1) begin
          tests_failed++;
          $display("FAIL rt_order vec=%h got code=%0d after %0d", vec, idx, prev);
        end
        exp_last = ((vec >> (idx + 1)) == '0);
        tests_run++;
        if (bus.code_last !== exp_last) begin
          tests_failed++;
          $display("FAIL rt_last vec=%h code=%0d got last=%b exp=%b", vec, idx, bus.code_last, exp_last);
        end
        acc  = acc | dec3to8(bus.code);
        prev = idx;
        cyc++;
        tick();
      end
      if (cyc > N) begin
        tests_run++;
        tests_failed++;
        $display("FAIL rt_timeout vec=%h codes did not end within %0d cycles", vec, N + 1);
      end
      tests_run++;
      if (acc !== vec) begin
        tests_failed++;
        $display("FAIL rt_rebuild got=%h exp=%h", acc, vec);
      end
      $display("[TB] roundtrip: vec=%h rebuilt=%h codes=%0d", vec, acc, cyc);
    end
  endtask

  task automatic test_reset_mid_send();
    bus.code_ready = 1'b1;
    offer(8'hFF);
    for (int j = 0; j < 2; j++) begin
      tests_run++;
      if (bus.code_valid !== 1'b1 || bus.code !== 3'(j)) begin
        tests_failed++;
        $display("FAIL midrst_pre%0d got valid=%b code=%0d exp 1/%0d", j, bus.code_valid, bus.code, j);
      end
      tick();
    end
    nrst = 1'b0;
    tick();
    tests_run++;
    if (bus.code_valid !== 1'b0 || bus.req_ready !== 1'b0 || bus.code_last !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_drop got valid=%b ready=%b last=%b exp 0/0/0",
               bus.code_valid, bus.req_ready, bus.code_last);
    end
    nrst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (bus.code_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.code !== 3'd0) begin
        tests_failed++;
        $display("FAIL midrst_after%0d got valid=%b ready=%b code=%0d exp 0/1/0",
                 k, bus.code_valid, bus.req_ready, bus.code);
      end
    end
    $display("[TB] reset mid-send: vector ff abandoned after 2 codes");
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_backpressure();
    test_zero_single();
    test_roundtrip();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
